// File: rtl/frame_pixel_decoder.sv
// frame_pixel_decoder
//
// Streams one frame of packed 4-bit palette indices from SRAM and emits 24-bit
// RGB pixels on a valid/ready stream. Each 16-bit SRAM word holds four pixels,
// unpacked MSB nibble first, and each index is looked up in a 16-entry colour map.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             one-cycle pulse that starts a frame (accepted only in idle)
//   i_base_addr         word address of the frame's first word, sampled on start
//   i_color_map         16-entry palette, index -> 24'hRRGGBB
//   o_sram_req          one-cycle read request
//   o_sram_addr         word address, valid with o_sram_req
//   i_sram_rvalid       read data valid (arrives at least one cycle after request)
//   i_sram_rdata        read word, pixel0 = [15:12] ... pixel3 = [3:0]
//   o_valid, i_ready    output pixel handshake
//   o_rgb               pixel colour
//   o_sof, o_eol        first pixel of frame / last pixel of line markers
//   o_busy              frame in progress
//   o_frame_done        one-cycle pulse after the last pixel is accepted

module frame_pixel_decoder #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_PIXELS = 480,
  parameter int unsigned ADDR_W   = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [23:0]       i_color_map [0:15],
  output logic              o_sram_req,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic              i_sram_rvalid,
  input  logic [15:0]       i_sram_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [23:0]       o_rgb,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int unsigned WORDS  = H_PIXELS * V_PIXELS / 4;
  localparam int unsigned WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned X_W    = $clog2(H_PIXELS);
  localparam int unsigned Y_W    = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_PIXELS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [WCNT_W-1:0]   word_cnt_q;
  logic                outstanding_q;

  // Two-entry word buffer
  logic [15:0]         buf_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          occ_q;

  // Unpacker and output register
  logic [1:0]          nib_q;
  logic                valid_q;
  logic [23:0]         rgb_q;

  // Position of the pixel currently held in the output register
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;

  logic                start_acc;
  logic                req;
  logic                push;
  logic                pop;
  logic                load;
  logic                accept;
  logic                last_pix;
  logic [15:0]         head_word;
  logic [3:0]          nibble;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    start_acc = (state_q == StIdle) && i_start;
    // Only one read in flight, and never more words committed than buffer slots.
    req       = (state_q == StRun) && !outstanding_q &&
                ((occ_q + {1'b0, outstanding_q}) < 2'd2);
    // Data with nothing outstanding is stale (e.g. from before a reset).
    push      = i_sram_rvalid && outstanding_q;
    accept    = valid_q && i_ready;
    last_pix  = accept && (x_q == X_LAST) && (y_q == Y_LAST);
    load      = (!valid_q || i_ready) && (occ_q != 2'd0);
    pop       = load && (nib_q == 2'd3);
    head_word = buf_q[rd_ptr_q];
  end

  always_comb begin
    nibble = head_word[15:12];
    case (nib_q)
      2'd0:    nibble = head_word[15:12];
      2'd1:    nibble = head_word[11:8];
      2'd2:    nibble = head_word[7:4];
      default: nibble = head_word[3:0];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = StRun;
      end
      StRun: begin
        if (req && (word_cnt_q == LAST_WORD)) state_d = StDrain;
      end
      StDrain: begin
        if (last_pix) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request side: base address, word counter, outstanding flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      base_q        <= '0;
      word_cnt_q    <= '0;
      outstanding_q <= 1'b0;
    end else begin
      if (start_acc) begin
        base_q     <= i_base_addr;
        word_cnt_q <= '0;
      end else if (req) begin
        word_cnt_q <= word_cnt_q + WCNT_W'(1);
      end

      if (req) begin
        outstanding_q <= 1'b1;
      end else if (push) begin
        outstanding_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= i_sram_rdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Unpacker and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      nib_q   <= '0;
      valid_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      if (load) begin
        nib_q   <= nib_q + 2'd1;
        valid_q <= 1'b1;
        // Palette is sampled here only, so a held pixel never changes colour.
        rgb_q   <= i_color_map[nibble];
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel position, advanced on acceptance
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      end else begin
        x_q <= x_q + X_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_sram_req   = req;
    o_sram_addr  = req ? (base_q + ADDR_W'(word_cnt_q)) : '0;
    o_valid      = valid_q;
    o_rgb        = rgb_q;
    // Position tracks the held pixel, so the markers stay stable during a stall.
    o_sof        = valid_q && (x_q == '0) && (y_q == '0);
    o_eol        = valid_q && (x_q == X_LAST);
    o_busy       = (state_q == StRun) || (state_q == StDrain);
    o_frame_done = (state_q == StDone);
  end

endmodule

// File: tb/tb_frame_pixel_decoder.sv
// tb_frame_pixel_decoder
//
// Self-checking bench for frame_pixel_decoder (8x2 frame, 20-bit addresses).
// An SRAM responder with programmable latency serves words from a per-frame
// word list; a reference model derives each expected pixel from the word list
// and palette with plain arithmetic and compares every accepted pixel.

module tb_frame_pixel_decoder;

  localparam int unsigned H     = 8;
  localparam int unsigned V     = 2;
  localparam int unsigned AW    = 20;
  localparam int unsigned WORDS = H * V / 4;
  localparam int unsigned NPIX  = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [23:0]   cmap [0:15];
  logic          sram_req;
  logic [AW-1:0] sram_addr;
  logic          sram_rvalid;
  logic [15:0]   sram_rdata;
  logic          valid;
  logic          ready;
  logic [23:0]   rgb;
  logic          sof;
  logic          eol;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  frame_pixel_decoder #(
    .H_PIXELS (H),
    .V_PIXELS (V),
    .ADDR_W   (AW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_base_addr   (base_addr),
    .i_color_map   (cmap),
    .o_sram_req    (sram_req),
    .o_sram_addr   (sram_addr),
    .i_sram_rvalid (sram_rvalid),
    .i_sram_rdata  (sram_rdata),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_rgb         (rgb),
    .o_sof         (sof),
    .o_eol         (eol),
    .o_busy        (busy),
    .o_frame_done  (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-frame model state
  logic [15:0]   frame_words [WORDS];
  logic [AW-1:0] exp_base;
  logic [23:0]   map_old [0:15];
  int            lat;
  int            ready_mode;
  int            req_cnt;
  int            delivered;
  int            acc;
  int            done_cnt;
  int            chg_idx;
  int            start_cyc;
  int            first_valid_cyc;
  int            pend_due [$];
  logic [15:0]   pend_data [$];
  bit            start_req;
  bit            poke_run, poked_run, poke_done, pal_test, changed;
  bit            prev_stall;
  logic [26:0]   prev_out;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Palette index of pixel p: word p/4, nibbles taken MSB first.
  function automatic logic [3:0] exp_nib(input int p);
    logic [15:0] w;
    int          sh;
    w  = frame_words[p / 4];
    sh = 12 - 4 * (p % 4);
    return 4'((w >> sh) & 16'hF);
  endfunction

  // One clock cycle: drive inputs at the falling edge, observe outputs there too.
  task automatic step();
    logic          r;
    logic          st;
    logic [26:0]   cur;
    logic [3:0]    nib;
    logic [23:0]   exp_rgb;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    cyc++;
    case (ready_mode)
      0:       r = 1'b1;
      1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: r = 1'($urandom_range(0, 1));
    endcase
    st = start_req;
    if (start_req) start_cyc = cyc;
    start_req = 1'b0;
    if (poke_run && !poked_run && busy && acc == 3) begin
      st        = 1'b1;
      poked_run = 1'b1;
      base_addr = AW'($urandom);
    end
    if (poke_done && frame_done) begin
      st        = 1'b1;
      base_addr = AW'($urandom);
    end
    if (pal_test && !changed && valid && acc == 5) begin
      r       = 1'b0;
      map_old = cmap;
      cmap[3] = 24'hff0000;
      chg_idx = acc;
      changed = 1'b1;
    end
    ready = r;
    start = st;

    cur = {valid, sof, eol, rgb};
    if (prev_stall) check_eq("stall_hold", 64'(cur), 64'(prev_out));
    prev_stall = valid && !r;
    prev_out   = cur;

    if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    if (sram_req) begin
      exp_addr = exp_base + AW'(req_cnt);
      check_eq("req_addr", 64'(sram_addr), 64'(exp_addr));
      check_eq("one_outstanding", 64'(pend_due.size()), 64'd0);
      check_eq("buf_room", 64'((delivered - (acc + int'(valid)) / 4) <= 1), 64'd1);
      pend_due.push_back(cyc + lat);
      pend_data.push_back((req_cnt < int'(WORDS)) ? frame_words[req_cnt] : 16'hdead);
      req_cnt++;
    end

    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      sram_rvalid = 1'b1;
      sram_rdata  = pend_data.pop_front();
      void'(pend_due.pop_front());
      delivered++;
    end else begin
      sram_rvalid = 1'b0;
      sram_rdata  = 16'($urandom);
    end

    if (valid && r) begin
      if (acc < int'(NPIX)) begin
        nib     = exp_nib(acc);
        exp_rgb = (changed && acc <= chg_idx) ? map_old[nib] : cmap[nib];
        check_eq("pix_rgb", 64'(rgb), 64'(exp_rgb));
        check_eq("pix_sof", 64'(sof), 64'(acc == 0));
        check_eq("pix_eol", 64'(eol), 64'((acc % H) == (H - 1)));
      end else begin
        check_eq("pix_count", 64'(acc), 64'(NPIX - 1));
      end
      acc++;
    end

    if (frame_done) done_cnt++;
  endtask

  task automatic setup_frame(input logic [AW-1:0] base, input int l, input int rmode,
                             input bit rand_words);
    logic [15:0] pat [4];
    pat = '{16'h0123, 16'h4567, 16'h89ab, 16'hcdef};
    for (int i = 0; i < int'(WORDS); i++) begin
      frame_words[i] = rand_words ? 16'($urandom) : pat[i % 4];
    end
    exp_base        = base;
    lat             = l;
    ready_mode      = rmode;
    req_cnt         = 0;
    delivered       = 0;
    acc             = 0;
    done_cnt        = 0;
    changed         = 1'b0;
    poked_run       = 1'b0;
    prev_stall      = 1'b0;
    first_valid_cyc = -1;
    base_addr       = base;
    start_req       = 1'b1;
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int l, input int rmode,
                           input bit rand_words);
    int guard;
    setup_frame(base, l, rmode, rand_words);
    guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      step();
      guard++;
    end
    check_eq("frame_timeout", 64'(guard < 3000), 64'd1);
    // First valid appears lat+2 cycles after the edge that accepts i_start.
    check_eq("first_latency", 64'(first_valid_cyc - start_cyc), 64'(l + 3));
    check_eq("req_total", 64'(req_cnt), 64'(WORDS));
    check_eq("pix_total", 64'(acc), 64'(NPIX));
    for (int i = 0; i < 5; i++) step();
    check_eq("done_pulses", 64'(done_cnt), 64'd1);
    check_eq("no_extra_req", 64'(req_cnt), 64'(WORDS));
    check_eq("idle_after", 64'({busy, valid}), 64'd0);
  endtask

  initial begin
    int  guard;
    bit  bad;
    rst         = 1'b1;
    start       = 1'b0;
    ready       = 1'b1;
    base_addr   = '0;
    sram_rvalid = 1'b0;
    sram_rdata  = '0;
    start_req   = 1'b0;
    poke_run    = 1'b0;
    poke_done   = 1'b0;
    pal_test    = 1'b0;
    lat         = 1;
    ready_mode  = 0;
    chg_idx     = -1;
    for (int i = 0; i < 16; i++) cmap[i] = 24'($urandom);
    cmap[3] = 24'h20232d;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             64'({sram_req, sram_addr, valid, rgb, sof, eol, busy, frame_done}), 64'd0);
    rst = 1'b0;
    step();

    // Basic frame, always ready, then a toggling ready pattern.
    run_frame(20'h00010, 1, 0, 1'b0);
    run_frame(20'h00010, 1, 1, 1'b0);
    // Address wrap-around.
    run_frame(20'hffffe, 1, 0, 1'b0);

    // Reset mid-frame with a request outstanding, then a late rvalid.
    setup_frame(20'h00400, 4, 0, 1'b0);
    guard = 0;
    while (pend_due.size() == 0 && guard < 100) begin
      step();
      guard++;
    end
    check_eq("reset_req_seen", 64'(pend_due.size()), 64'd1);
    step();
    rst = 1'b1;
    #1;
    check_eq("midframe_reset",
             64'({sram_req, sram_addr, valid, rgb, sof, eol, busy, frame_done}), 64'd0);
    step();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid || busy || sram_req || frame_done) bad = 1'b1;
    end
    check_eq("late_rvalid_sent", 64'(delivered), 64'd1);
    check_eq("late_rvalid_ignored", 64'(bad), 64'd0);
    run_frame(20'h00400, 1, 0, 1'b0);

    // Ignored starts during RUN and DONE, plus a palette change during a stall.
    poke_run  = 1'b1;
    poke_done = 1'b1;
    pal_test  = 1'b1;
    run_frame(20'h00100, 2, 0, 1'b0);
    check_eq("pal_change_done", 64'(changed), 64'd1);
    poke_run  = 1'b0;
    poke_done = 1'b0;
    pal_test  = 1'b0;
    changed   = 1'b0;
    cmap[3]   = 24'h20232d;

    // Slow SRAM.
    run_frame(20'h02000, 5, 0, 1'b0);

    // Randomised frames.
    for (int f = 0; f < 6; f++) begin
      run_frame(AW'($urandom), int'($urandom_range(1, 5)), 2, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_pixel_decoder.md
Name: frame_pixel_decoder

Overview:
Streams one frame of 4-bit palette indices out of SRAM and emits 24-bit RGB pixels for the display path. It reads packed 16-bit words (4 pixels/word), unpacks them MSB-nibble first, and looks each index up in the 16-entry colour map driven by the active palette module. Its output feeds the VGA line/pixel stage through a valid/ready stream.

Parameters:
H_PIXELS, 640, pixels per line; must be a multiple of 4
V_PIXELS, 480, lines per frame
ADDR_W, 20, SRAM word-address width

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_start  input  1  one-cycle pulse that begins a frame; ignored while o_busy=1
i_base_addr  input  ADDR_W  SRAM word address of the frame's first word, sampled on accepted i_start
i_color_map  input  24 x [0:15]  palette array, index -> 24'hRRGGBB
o_sram_req  output  1  read request, one-cycle pulse
o_sram_addr  output  ADDR_W  word address, valid with o_sram_req
i_sram_rvalid  input  1  read data valid, at least 1 cycle after request
i_sram_rdata  input  16  read word, pixel0=[15:12] ... pixel3=[3:0]
o_valid  output  1  output pixel valid
i_ready  input  1  downstream accepts when o_valid & i_ready
o_rgb  output  24  pixel colour
o_sof  output  1  high with first pixel of frame
o_eol  output  1  high with last pixel of each line
o_busy  output  1  frame in progress
o_frame_done  output  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; counters, buffer and outstanding flag cleared.
- FSM: IDLE -> RUN on i_start; RUN -> DRAIN when last word requested; DRAIN -> DONE when last pixel accepted; DONE -> IDLE after one cycle (o_frame_done=1 in DONE only). o_busy=1 in RUN and DRAIN.
- Words per frame = H_PIXELS*V_PIXELS/4. Word address = base + word_count, ADDR_W-bit wrap-around modulo 2^ADDR_W.
- Word buffer: 2 entries. At most one request outstanding. Issue o_sram_req in RUN when no request is outstanding and occupancy + outstanding < 2. Push on i_sram_rvalid. Ignore i_sram_rvalid when no request is outstanding, including after a mid-frame reset.
- Unpacker: a nibble pointer runs 0..3 over the head word. The head entry pops when the pointer's 4th pixel loads into the output register.
- Output register: load when (!o_valid | i_ready) and a head word is present. o_rgb = i_color_map[nibble], registered, so latency is 1 cycle from load.
  - While o_valid & !i_ready, hold o_rgb/o_sof/o_eol stable.
- Latency from i_start to first o_valid: 2 cycles + SRAM latency.
- Pixel x counter 0..H_PIXELS-1, y counter 0..V_PIXELS-1, both advanced on acceptance.
  - o_sof = (x==0 & y==0) on the loaded pixel.
  - o_eol = (x==H_PIXELS-1).
- Palette change mid-frame takes effect on the next loaded pixel. No pixel already in the register changes.
- Simultaneous push and pop on the buffer are both honoured. Occupancy never exceeds 2.
- i_start asserted in the same cycle as DONE is ignored. It is accepted from IDLE only.

Test Plan:
- H=8,V=2, base=0x00010, SRAM latency 1, i_ready=1, words 0x0123,0x4567,0x89AB,0xCDEF repeated -> 4 requests at 0x10..0x13. Output is 16 pixels with colours map[0..15] in nibble order, o_sof on pixel 0, o_eol on pixels 7 and 15, then o_frame_done one pulse.
- Same frame, i_ready toggling 1,0,0,1 -> each pixel held stable while stalled, no pixel lost or duplicated, at most 2 words buffered, no request while full.
- base=0xFFFFE (ADDR_W=20), 4 words -> addresses 0xFFFFE,0xFFFFF,0x00000,0x00001.
- Assert i_rst mid-frame with a request outstanding, then deliver a late i_sram_rvalid -> all outputs 0, state IDLE, late data ignored. A new i_start then runs a clean frame starting at o_sof.
- i_start pulsed during RUN and in the DONE cycle -> ignored, no extra requests. Change i_color_map[3] from 24'h20232d to 24'hff0000 mid-frame -> later index-3 pixels output 24'hff0000, the held pixel is unchanged.
- SRAM latency 5 cycles -> single outstanding request, frame completes with correct order and exactly V*H/4 requests.
